// File: rtl/risky_mem_pkg.sv
// rtl/risky_mem_pkg.sv - shared types and limits for the data-side memory responder
package risky_mem_pkg;

  typedef enum logic [1:0] {
    MEM_SIZE_B = 2'd0,
    MEM_SIZE_H = 2'd1,
    MEM_SIZE_W = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } data_memory_state_e;

  localparam int MAX_LATENCY = 15;

endpackage

// File: rtl/data_memory_lane.sv
// rtl/data_memory_lane.sv - byte-lane steering: store merge, byte enables, load extension, alignment
module data_memory_lane
  import risky_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] store_word,
  output logic [3:0]  byte_en,
  output logic [31:0] load_value,
  output logic        misalign
);

  logic [31:0] wdata_rep;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the lanes touched by the access and replicate the right-aligned data across them
  always_comb begin
    byte_en   = 4'b0000;
    wdata_rep = wdata;
    misalign  = 1'b0;
    case (size)
      MEM_SIZE_B: begin
        byte_en   = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      MEM_SIZE_H: begin
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        misalign  = addr_lo[0];
      end
      MEM_SIZE_W: begin
        byte_en  = 4'b1111;
        misalign = (addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

  // Enabled lanes take new data, all other bytes keep the old word
  always_comb begin
    store_word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) store_word[8*i +: 8] = wdata_rep[8*i +: 8];
    end
  end

  // Extract the addressed byte or half and extend it; word loads pass straight through
  always_comb begin
    byte_sel   = old_word[{addr_lo, 3'b000} +: 8];
    half_sel   = addr_lo[1] ? old_word[31:16] : old_word[15:0];
    load_value = '0;
    case (size)
      MEM_SIZE_B: load_value = is_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      MEM_SIZE_H: load_value = is_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      MEM_SIZE_W: load_value = old_word;
      default:    load_value = '0;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// rtl/data_memory.sv - load/store responder with fixed latency; optional counters under DATA_MEMORY_STATS_EN
module data_memory
  import risky_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
`ifdef DATA_MEMORY_STATS_EN
  ,
  output logic [31:0] load_count_o,
  output logic [31:0] store_count_o,
  output logic [31:0] err_count_o
`endif
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = $clog2(MAX_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;
  localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);

  data_memory_state_e state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;

  logic        cap_we, cap_unsigned;
  logic [1:0]  cap_size;
  logic [31:0] cap_addr, cap_wdata;

  logic        cur_we, cur_unsigned;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr, cur_wdata;

  logic             accept, commit, out_of_range, access_err;
  logic [IDX_W-1:0] idx;
  logic [31:0]      old_word, store_word, load_value;
  logic [3:0]       byte_en;
  logic             misalign;

  logic [31:0] mem [DEPTH_WORDS];

  assign req_ready_o = (state_q == IDLE) && !rst;
  assign rsp_valid_o = (state_q == RESP);
  assign accept      = req_valid_i && req_ready_o;

  // With LATENCY == 1 the access commits in the accept cycle, so it must use the live request
  assign cur_we       = (state_q == IDLE) ? req_we_i       : cap_we;
  assign cur_unsigned = (state_q == IDLE) ? req_unsigned_i : cap_unsigned;
  assign cur_size     = (state_q == IDLE) ? req_size_i     : cap_size;
  assign cur_addr     = (state_q == IDLE) ? req_addr_i     : cap_addr;
  assign cur_wdata    = (state_q == IDLE) ? req_wdata_i    : cap_wdata;

  assign out_of_range = (cur_addr[31:2] >= DEPTH_LIMIT);
  assign idx          = cur_addr[IDX_W+1:2];
  assign old_word     = out_of_range ? '0 : mem[idx];
  assign access_err   = (cur_size == 2'd3) || misalign || out_of_range;
  assign commit       = (state_q != RESP) && (state_d == RESP) && !rst;

  data_memory_lane u_lane (
    .size        (cur_size),
    .is_unsigned (cur_unsigned),
    .addr_lo     (cur_addr[1:0]),
    .old_word    (old_word),
    .wdata       (cur_wdata),
    .store_word  (store_word),
    .byte_en     (byte_en),
    .load_value  (load_value),
    .misalign    (misalign)
  );

  // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP until taken
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and latency counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && accept) begin
        cnt_q <= CNT_INIT;
      end else if ((state_q == WAIT) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Hold the accepted request for the WAIT/RESP phases
  always_ff @(posedge clk) begin
    if (accept) begin
      cap_we       <= req_we_i;
      cap_unsigned <= req_unsigned_i;
      cap_size     <= req_size_i;
      cap_addr     <= req_addr_i;
      cap_wdata    <= req_wdata_i;
    end
  end

  // Register the response on the commit cycle; it then stays stable through RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else if (commit) begin
      rsp_err_o   <= access_err;
      rsp_rdata_o <= (!cur_we && !access_err) ? load_value : '0;
    end
  end

  // Store commit: only enabled lanes of an error-free store are written
  always_ff @(posedge clk) begin
    if (commit && cur_we && !access_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx][8*i +: 8] <= store_word[8*i +: 8];
      end
    end
  end

`ifdef DATA_MEMORY_STATS_EN
  // Saturating completion counters, bumped on the RESP -> IDLE handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      load_count_o  <= '0;
      store_count_o <= '0;
      err_count_o   <= '0;
    end else if ((state_q == RESP) && rsp_ready_i) begin
      if (rsp_err_o) begin
        if (err_count_o != '1) err_count_o <= err_count_o + 32'd1;
      end else if (cap_we) begin
        if (store_count_o != '1) store_count_o <= store_count_o + 32'd1;
      end else begin
        if (load_count_o != '1) load_count_o <= load_count_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Data-side memory responder for the risky pipeline; the other end of the load/store requests issued by the mem_access stage.
- Accepts one load or store per valid/ready handshake and performs byte, half or word access on an internal word-organised array.
- Returns a response (load data or store acknowledge, plus error flag) after a fixed, parameterised latency, held until the requester takes it.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; word index = req_addr_i[31:2].
- LATENCY, 1, cycles from request acceptance to rsp_valid_o; legal range 1..15.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  responder can accept a request.
- req_we_i  input  1  1 = store, 0 = load.
- req_size_i  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned_i  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr_i  input  32  byte address.
- req_wdata_i  input  32  store data, right-aligned.
- rsp_valid_o  output  1  response present.
- rsp_ready_i  input  1  requester takes response.
- rsp_rdata_o  output  32  load result, extended; 0 for stores and errors.
- rsp_err_o  output  1  misaligned, out of range or illegal size.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- Reset: state = IDLE, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0, latency counter = 0. Array contents are not reset.
- req_ready_o = (state == IDLE) && !rst. It is combinational from state and never depends on req_valid_i.
- FSM states:
  - IDLE: on req_valid_i && req_ready_o, capture we, size, unsigned, addr and wdata. If LATENCY == 1, go to RESP; otherwise go to WAIT and load counter = LATENCY-2.
  - WAIT: decrement counter each cycle. When counter == 0, go to RESP.
  - RESP: rsp_valid_o = 1, with rdata and err stable. On rsp_ready_i, go to IDLE. Otherwise hold all response outputs unchanged.
- Access commits on the transition into RESP. In that cycle the store writes the array, or the load reads it and registers the result.
- Minimum spacing between acceptances is LATENCY+1 cycles. No acceptance occurs while in RESP.
- Error checks, evaluated on the captured request:
  - size == 3;
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - addr[31:2] >= DEPTH_WORDS.
  - On error: rsp_err_o = 1, rsp_rdata_o = 0, and the array is not written.
- Stores:
  - Byte: lane addr[1:0] receives wdata[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1} receive wdata[15:0].
  - Word: full 32 bits.
  - All other bytes of the word are preserved.
  - rsp_rdata_o = 0.
- Loads: extract the addressed byte or half, then sign- or zero-extend per unsigned. Word loads ignore unsigned.
- Load after store to the same address returns the new data, because the store committed in an earlier cycle.
- rst asserted in any state: the next cycle is IDLE with outputs at reset values. A store in WAIT is dropped; a store already committed stays written.
- rsp_ready_i while not in RESP is ignored.

Optional Feature:
- Macro DATA_MEMORY_STATS_EN.
- Defined: adds three output ports, each 32 bits wide: load_count_o, store_count_o and err_count_o.
  - Each increments by 1 on the RESP->IDLE handshake of the matching kind. An errored access increments only err_count_o.
  - Counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package risky_mem_pkg holds:
  - mem_size_e (MEM_SIZE_B = 2'd0, MEM_SIZE_H = 2'd1, MEM_SIZE_W = 2'd2);
  - data_memory_state_e (IDLE, WAIT, RESP);
  - localparam MAX_LATENCY = 15.
- One natural sub-module, data_memory_lane, which is combinational. Given size, unsigned, addr[1:0], old word and wdata, it produces:
  - the merged store word and 4-bit byte-enable;
  - the extended load value;
  - the misalign flag.

Test Plan:
- LATENCY = 1. Store word 0xDEADBEEF @0x10, then load word @0x10. Expected: each rsp_valid_o rises 1 cycle after acceptance; load rdata = 0xDEADBEEF, err = 0.
- Store byte 0x80 @0x13 over 0x11223344, then signed byte load @0x13 and unsigned byte load @0x13. Expected: word = 0x80223344; signed rdata = 0xFFFFFF80; unsigned rdata = 0x00000080.
- LATENCY = 4. Half store 0xA5A5 @0x20 with rsp_ready_i held low 3 cycles. Expected: rsp_valid_o rises 4 cycles after acceptance and is held; req_ready_o stays 0 until the cycle after the handshake.
- Word load @0x22, half store @0x21, size = 3 @0x0, and load @(DEPTH_WORDS*4). Expected: every response has err = 1 and rdata = 0; array contents are unchanged.
- rst asserted in WAIT during a store @0x30 (LATENCY = 3). Expected: next cycle is IDLE with req_ready_o = 1 and rsp_valid_o = 0; a subsequent load @0x30 returns the prior contents.
- With DATA_MEMORY_STATS_EN: 2 loads, 1 store, 1 misaligned load. Expected: load_count_o = 2, store_count_o = 1, err_count_o = 1.
